// File: rtl/cluster_periph_slice_pkg.sv
// Shared helpers for the cluster peripheral decoupling slice.
// Latency: none (package only).
// Backpressure: n/a.
// Contents: parameter sanity helper and the response-error encoding.
package cluster_periph_slice_pkg;

  // Response opcode values carried on slv_r_opc_o.
  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  // True when v is a non-zero power of two; used for elaboration checks.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cluster_periph_slice_fifo.sv
// Request queue: registered FIFO of DEPTH entries, no fall-through.
// Latency: a push in cycle t is visible on data_o / empty_o in t+1.
// Backpressure: push ignored when full_o, pop ignored when empty_o.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write
//        side; pop_i/data_o read side (data_o is the head); full_o/empty_o.
module cluster_periph_slice_fifo
  import cluster_periph_slice_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_push;
  logic                  w_pop;

  assign full_o  = (r_count == (PW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cluster_periph_slice.sv
// Decouples the core peripheral port from the interconnect: queued requests, registered responses, outstanding cap.
// Latency: request t -> mst_req_o t+1; mst_r_valid_i t -> slv_r_valid_o t+1.
// Backpressure: slv_gnt_o drops when the queue is full or MAX_OUTSTANDING requests are unanswered; response path has none.
// Ports: slv_* core-side request/response, mst_* interconnect side (mst_id_o = core_id_i),
//        stall_o = request refused this cycle, busy_o = anything queued or in flight.
module cluster_periph_slice
  import cluster_periph_slice_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH        = 5,
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ID_WIDTH-1:0]   core_id_i,
  input  logic                  slv_req_i,
  input  logic [ADDR_WIDTH-1:0] slv_add_i,
  input  logic                  slv_wen_i,
  input  logic [DATA_WIDTH-1:0] slv_wdata_i,
  input  logic [BE_WIDTH-1:0]   slv_be_i,
  output logic                  slv_gnt_o,
  output logic                  slv_r_valid_o,
  output logic                  slv_r_opc_o,
  output logic [DATA_WIDTH-1:0] slv_r_rdata_o,
  output logic                  mst_req_o,
  output logic [ADDR_WIDTH-1:0] mst_add_o,
  output logic                  mst_wen_o,
  output logic [DATA_WIDTH-1:0] mst_wdata_o,
  output logic [BE_WIDTH-1:0]   mst_be_o,
  output logic [ID_WIDTH-1:0]   mst_id_o,
  input  logic                  mst_gnt_i,
  input  logic                  mst_r_valid_i,
  input  logic                  mst_r_opc_i,
  input  logic [DATA_WIDTH-1:0] mst_r_rdata_i,
  input  logic [ID_WIDTH-1:0]   mst_r_id_i,
  output logic                  stall_o,
  output logic                  busy_o
);

  localparam int unsigned FW = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("cluster_periph_slice: DEPTH must be a power of two and at least 2");
  end
  if (MAX_OUTSTANDING < DEPTH || MAX_OUTSTANDING > 255) begin : g_bad_max_out
    $error("cluster_periph_slice: MAX_OUTSTANDING must be in [DEPTH, 255]");
  end

  logic [FW-1:0]         w_fifo_in;
  logic [FW-1:0]         w_fifo_out;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rsp_accept;
  logic [CW-1:0]         r_outstanding;
  logic                  r_rsp_vld;
  logic                  r_rsp_opc;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Grant only looks at registered state so it cannot combinationally loop
  // back through slv_req_i in the demux.
  assign slv_gnt_o = ~w_fifo_full & (r_outstanding < CW'(MAX_OUTSTANDING));
  assign w_push    = slv_req_i & slv_gnt_o;
  assign w_pop     = mst_req_o & mst_gnt_i;
  assign stall_o   = slv_req_i & ~slv_gnt_o;
  assign busy_o    = (r_outstanding != '0) | ~w_fifo_empty;

  assign w_fifo_in = {slv_add_i, slv_wen_i, slv_wdata_i, slv_be_i};
  assign mst_req_o = ~w_fifo_empty;
  assign {mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o} = w_fifo_out;
  assign mst_id_o  = core_id_i;

  cluster_periph_slice_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (FW)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_fifo_in),
    .pop_i   (w_pop),
    .data_o  (w_fifo_out),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // The counter only decrements when the registered response leaves, so a
  // response already sitting in the register is not yet reflected in it.
  // Subtract it before deciding whether a new response has an owner;
  // otherwise the counter could underflow.
  assign w_rsp_accept = mst_r_valid_i & (r_outstanding > CW'(r_rsp_vld));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else begin
      case ({w_push, r_rsp_vld})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // A response carrying a foreign ID is still forwarded to keep ordering,
  // but flagged as an error to the core.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_opc   <= OPC_OK;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_vld <= w_rsp_accept;
      if (w_rsp_accept) begin
        r_rsp_rdata <= mst_r_rdata_i;
        r_rsp_opc   <= (mst_r_id_i != core_id_i) ? OPC_ERR : mst_r_opc_i;
      end
    end
  end

  assign slv_r_valid_o = r_rsp_vld;
  assign slv_r_opc_o   = r_rsp_opc;
  assign slv_r_rdata_o = r_rsp_rdata;

  // A response with nothing outstanding is dropped; flag it in simulation.
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_r_valid_i |-> (r_outstanding > CW'(r_rsp_vld)));

endmodule

// File: tb/tb_cluster_periph_slice.sv
module tb_cluster_periph_slice;

  localparam int AW = 32, DW = 32, BW = 4, IW = 5, DEPTH = 2, MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [IW-1:0] core_id_i;
  logic          slv_req_i, slv_wen_i;
  logic [AW-1:0] slv_add_i;
  logic [DW-1:0] slv_wdata_i;
  logic [BW-1:0] slv_be_i;
  logic          slv_gnt_o, slv_r_valid_o, slv_r_opc_o;
  logic [DW-1:0] slv_r_rdata_o;
  logic          mst_req_o, mst_wen_o;
  logic [AW-1:0] mst_add_o;
  logic [DW-1:0] mst_wdata_o;
  logic [BW-1:0] mst_be_o;
  logic [IW-1:0] mst_id_o, mst_r_id_i;
  logic          mst_gnt_i, mst_r_valid_i, mst_r_opc_i;
  logic [DW-1:0] mst_r_rdata_i;
  logic          stall_o, busy_o;

  always #5 clk = ~clk;

  cluster_periph_slice #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW),
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .core_id_i(core_id_i),
    .slv_req_i(slv_req_i), .slv_add_i(slv_add_i), .slv_wen_i(slv_wen_i),
    .slv_wdata_i(slv_wdata_i), .slv_be_i(slv_be_i), .slv_gnt_o(slv_gnt_o),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_opc_o(slv_r_opc_o),
    .slv_r_rdata_o(slv_r_rdata_o), .mst_req_o(mst_req_o), .mst_add_o(mst_add_o),
    .mst_wen_o(mst_wen_o), .mst_wdata_o(mst_wdata_o), .mst_be_o(mst_be_o),
    .mst_id_o(mst_id_o), .mst_gnt_i(mst_gnt_i), .mst_r_valid_i(mst_r_valid_i),
    .mst_r_opc_i(mst_r_opc_i), .mst_r_rdata_i(mst_r_rdata_i),
    .mst_r_id_i(mst_r_id_i), .stall_o(stall_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  // Reference model: requests waiting in the slice, accepted-but-unanswered
  // count, requests handed to the interconnect but not yet answered, and the
  // response the core should see in the coming cycle.
  req_t          q[$];
  int            outst = 0;
  int            sent = 0;
  bit            rsp_pend = 0;
  logic [DW-1:0] rsp_data = '0;
  logic          rsp_opc = 1'b0;
  logic          dut_gnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic tick();
    logic eg;
    @(negedge clk);
    eg = (q.size() < DEPTH) && (outst < MAXO);
    chk("slv_gnt", slv_gnt_o, eg);
    chk("stall", stall_o, slv_req_i & ~eg);
    chk("mst_req", mst_req_o, q.size() != 0);
    chk("busy", busy_o, (outst != 0) || (q.size() != 0));
    chk("mst_id", mst_id_o, core_id_i);
    chk("r_valid", slv_r_valid_o, rsp_pend);
    if (q.size() != 0) begin
      chk("mst_add", mst_add_o, q[0].add);
      chk("mst_wen", mst_wen_o, q[0].wen);
      chk("mst_wdata", mst_wdata_o, q[0].wdata);
      chk("mst_be", mst_be_o, q[0].be);
    end
    if (rsp_pend) begin
      chk("r_rdata", slv_r_rdata_o, rsp_data);
      chk("r_opc", slv_r_opc_o, rsp_opc);
    end
    dut_gnt = slv_gnt_o;
    @(posedge clk);
    if (q.size() != 0 && mst_gnt_i) begin
      q.delete(0);
      sent++;
    end
    if (slv_req_i && eg) begin
      q.push_back('{slv_add_i, slv_wen_i, slv_wdata_i, slv_be_i});
      outst++;
    end
    if (rsp_pend) outst--;
    rsp_pend = mst_r_valid_i;
    if (mst_r_valid_i) begin
      rsp_data = mst_r_rdata_i;
      rsp_opc  = mst_r_opc_i | (mst_r_id_i != core_id_i);
    end
    #1;
  endtask

  task automatic set_req(input bit v, input logic [AW-1:0] a, input bit wen);
    slv_req_i   = v;
    slv_add_i   = a;
    slv_wen_i   = wen;
    slv_wdata_i = $urandom;
    slv_be_i    = BW'($urandom);
  endtask

  // Drive a response only if some request is actually in flight.
  task automatic set_rsp(input bit v, input logic [DW-1:0] d, input bit opc, input bit bad_id);
    if (v && sent > 0) begin
      mst_r_valid_i = 1'b1;
      mst_r_rdata_i = d;
      mst_r_opc_i   = opc;
      mst_r_id_i    = bad_id ? core_id_i + 1'b1 : core_id_i;
      sent--;
    end else begin
      mst_r_valid_i = 1'b0;
      mst_r_rdata_i = '0;
      mst_r_opc_i   = 1'b0;
      mst_r_id_i    = core_id_i;
    end
  endtask

  task automatic drain();
    int n = 0;
    slv_req_i = 1'b0;
    mst_gnt_i = 1'b1;
    while ((outst != 0 || q.size() != 0 || rsp_pend) && n < 40) begin
      set_rsp(1'b1, $urandom, 1'b0, 1'b0);
      tick();
      n++;
    end
    set_rsp(1'b0, '0, 1'b0, 1'b0);
    chk("drain_done", busy_o, 1'b0);
  endtask

  initial begin
    int n_gr;
    core_id_i = 5'd7;
    rst_ni    = 1'b0;
    mst_gnt_i = 1'b0;
    set_req(1'b1, '0, 1'b0);
    set_rsp(1'b0, '0, 1'b0, 1'b0);
    #2;
    chk("rst_gnt", slv_gnt_o, 1'b1);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_r_valid", slv_r_valid_o, 1'b0);
    chk("rst_r_opc", slv_r_opc_o, 1'b0);
    chk("rst_r_rdata", slv_r_rdata_o, 32'h0);
    chk("rst_mst_req", mst_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    set_req(1'b0, '0, 1'b0);

    // Single read, answered two cycles after it reaches the interconnect.
    mst_gnt_i = 1'b1;
    set_req(1'b1, 32'h1000_0010, 1'b1);
    tick();
    set_req(1'b0, '0, 1'b0);
    tick();
    tick();
    set_rsp(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    tick();
    set_rsp(1'b0, '0, 1'b0, 1'b0);
    chk("rd_valid", slv_r_valid_o, 1'b1);
    chk("rd_data", slv_r_rdata_o, 32'hCAFE_F00D);
    tick();
    chk("rd_busy_idle", busy_o, 1'b0);

    // Interconnect stalled: queue fills after two, third request stalls.
    mst_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'h2000_0000 + 32'(4 * i), 1'b0);
      tick();
    end
    chk("full_stall", dut_gnt, 1'b0);
    mst_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dut_gnt) set_req(1'b0, '0, 1'b0);
    end
    drain();

    // No responses: the outstanding cap admits exactly four.
    n_gr = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 32'h3000_0000 + 32'(i), 1'b1);
      tick();
      if (dut_gnt) n_gr++;
    end
    chk("cap_granted", n_gr, 4);
    set_rsp(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    set_rsp(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("cap_reopen", dut_gnt, 1'b1);
    set_req(1'b0, '0, 1'b0);
    drain();

    // Response with a foreign ID is forwarded as an error.
    set_req(1'b1, 32'h4000_0000, 1'b1);
    tick();
    set_req(1'b0, '0, 1'b0);
    tick();
    set_rsp(1'b1, 32'h0BAD_0001, 1'b0, 1'b1);
    tick();
    set_rsp(1'b0, '0, 1'b0, 1'b0);
    chk("badid_valid", slv_r_valid_o, 1'b1);
    chk("badid_opc", slv_r_opc_o, 1'b1);
    drain();

    // Request and response leaving in the same cycle at three outstanding.
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
      tick();
    end
    set_req(1'b0, '0, 1'b0);
    set_rsp(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
    tick();
    set_rsp(1'b0, '0, 1'b0, 1'b0);
    set_req(1'b1, 32'h5000_0010, 1'b1);
    tick();
    chk("simul_gnt", dut_gnt, 1'b1);
    tick();
    chk("simul_gnt_next", dut_gnt, 1'b1);
    set_req(1'b0, '0, 1'b0);
    tick();
    chk("simul_cap", slv_gnt_o, 1'b0);
    drain();

    // Reset mid-operation: one in flight, two queued.
    set_req(1'b1, 32'h6000_0000, 1'b0);
    tick();
    set_req(1'b1, 32'h6000_0004, 1'b0);
    tick();
    mst_gnt_i = 1'b0;
    set_req(1'b1, 32'h6000_0008, 1'b0);
    tick();
    chk("pre_rst_busy", busy_o, 1'b1);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_gnt", slv_gnt_o, 1'b1);
    chk("mid_rst_stall", stall_o, 1'b0);
    chk("mid_rst_mst_req", mst_req_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_r_valid", slv_r_valid_o, 1'b0);
    chk("mid_rst_r_rdata", slv_r_rdata_o, 32'h0);
    q.delete();
    outst    = 0;
    sent     = 0;
    rsp_pend = 0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    set_req(1'b0, '0, 1'b0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_req(($urandom_range(0, 9) < 6), $urandom, $urandom_range(0, 1));
      mst_gnt_i = ($urandom_range(0, 1) == 1);
      set_rsp(($urandom_range(0, 9) < 4), $urandom, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 9) == 0));
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
